bin2sseg: RTL and testbench

BIN2SSEG -- requirements
Module: bin2sseg

---
 rtl/bin2sseg.sv | 135 +++++++++++++
 tb/tb_bin2sseg.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2sseg.sv
// ============================================================================
// Module   : bin2sseg
// Purpose  : 8-bit binary to three-digit active-low seven-segment converter
//            using a sequential double-dabble core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2sseg #(
    parameter int LZB = 1,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   bin,
    input  logic [2:0]   dp,
    output logic [W-1:0] seg0,
    output logic [W-1:0] seg1,
    output logic [W-1:0] seg2,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [7:0]  bin_q;
    logic [2:0]  dp_q;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [2:0]  cnt;
    logic        blank_hundreds;
    logic        blank_tens;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Bit 7 of the table entries is the (inactive) decimal point.
    function automatic logic [7:0] encode(input logic [3:0] n,
                                          input logic       blank,
                                          input logic       point);
        logic [7:0] p;
        if (blank) begin
            p = 8'hFF;
        end else begin
            case (n)
                4'd0:    p = 8'hC0;
                4'd1:    p = 8'hF9;
                4'd2:    p = 8'hA4;
                4'd3:    p = 8'hB0;
                4'd4:    p = 8'h99;
                4'd5:    p = 8'h92;
                4'd6:    p = 8'h82;
                4'd7:    p = 8'hF8;
                4'd8:    p = 8'h80;
                4'd9:    p = 8'h90;
                default: p = 8'hFF;
            endcase
        end
        p[7] = ~point;
        return p;
    endfunction

    assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};

    assign blank_hundreds = (LZB != 0) && (bcd[11:8] == 4'd0);
    assign blank_tens     = blank_hundreds && (bcd[7:4] == 4'd0);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (cnt == 3'd7) next_state = LOAD;
            LOAD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q <= 8'd0;
            dp_q  <= 3'd0;
            bcd   <= 12'd0;
            cnt   <= 3'd0;
            seg0  <= '1;
            seg1  <= '1;
            seg2  <= '1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q <= bin;
                        dp_q  <= dp;
                        bcd   <= 12'd0;
                        cnt   <= 3'd0;
                    end
                end
                SHIFT: begin
                    {bcd, bin_q} <= {bcd_adj, bin_q} << 1;
                    cnt          <= cnt + 3'd1;
                end
                LOAD: begin
                    seg0 <= W'(encode(bcd[3:0],  1'b0,           dp_q[0]));
                    seg1 <= W'(encode(bcd[7:4],  blank_tens,     dp_q[1]));
                    seg2 <= W'(encode(bcd[11:8], blank_hundreds, dp_q[2]));
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bin2sseg.sv
// ============================================================================
// Module   : tb_bin2sseg
// Purpose  : Directed and sweep testbench for bin2sseg (LZB=1 and LZB=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2sseg;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic [7:0] bin   = 8'd0;
    logic [2:0] dp    = 3'd0;

    logic [7:0] s0a, s1a, s2a, s0b, s1b, s2b;
    logic       busy_a, done_a, busy_b, done_b;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_n;
    bit hold_ok;
    bit done_b_ok;

    always #5 clk = ~clk;

    bin2sseg #(.LZB(1), .W(8)) dut_lzb (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .dp(dp),
        .seg0(s0a), .seg1(s1a), .seg2(s2a), .busy(busy_a), .done(done_a)
    );

    bin2sseg #(.LZB(0), .W(8)) dut_nolzb (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .dp(dp),
        .seg0(s0b), .seg1(s1b), .seg2(s2b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [7:0] ref_digit(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Decimal reference: returns {seg2, seg1, seg0}
    function automatic logic [23:0] ref_segs(input int b, input logic [2:0] d, input bit lzb);
        int h, t, o;
        logic [7:0] p2, p1, p0;
        h  = b / 100;
        t  = (b / 10) % 10;
        o  = b % 10;
        p2 = (lzb && h == 0) ? 8'hFF : ref_digit(h);
        p1 = (lzb && h == 0 && t == 0) ? 8'hFF : ref_digit(t);
        p0 = ref_digit(o);
        if (d[2]) p2[7] = 1'b0;
        if (d[1]) p1[7] = 1'b0;
        if (d[0]) p0[7] = 1'b0;
        return {p2, p1, p0};
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or timeout).
    task automatic run_conv(input logic [7:0] b, input logic [2:0] d);
        logic [23:0] prev;
        prev      = {s2a, s1a, s0a};
        bin       = b;
        dp        = d;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        lat       = -1;
        busy_n    = 0;
        hold_ok   = 1'b1;
        done_b_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done_b !== done_a) done_b_ok = 1'b0;
            if (done_a) begin
                lat = i;
                break;
            end
            if (busy_a) busy_n++;
            if ({s2a, s1a, s0a} !== prev) hold_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({s2a, s1a, s0a} !== 24'hFFFFFF || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got segs=%h busy=%b done=%b expected FFFFFF 0 0",
                     {s2a, s1a, s0a}, busy_a, done_a);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero;
        run_conv(8'd0, 3'd0);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL zero_latency: got %0d expected 9", lat);
        end
        checks++;
        if ({s2a, s1a, s0a} !== 24'hFFFFC0) begin
            errors++;
            $display("FAIL zero_segs: got %h expected FFFFC0", {s2a, s1a, s0a});
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL busy_with_done: got %b expected 0", busy_a);
        end
        checks++;
        if ({s2b, s1b, s0b} !== 24'hC0C0C0) begin
            errors++;
            $display("FAIL zero_segs_nolzb: got %h expected C0C0C0", {s2b, s1b, s0b});
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got done=%b busy=%b expected 0 0", done_a, busy_a);
        end
    endtask

    task automatic test_max;
        run_conv(8'd255, 3'd0);
        checks++;
        if ({s2a, s1a, s0a} !== 24'hA49292) begin
            errors++;
            $display("FAIL max_segs: got %h expected A49292", {s2a, s1a, s0a});
        end
        checks++;
        if (busy_n !== 9) begin
            errors++;
            $display("FAIL max_busy_cycles: got %0d expected 9", busy_n);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL seg_hold: got changed expected held segs during conversion");
        end
    endtask

    task automatic test_internal_zero_dp;
        run_conv(8'd107, 3'b001);
        checks++;
        if ({s2a, s1a, s0a} !== 24'hF9C078) begin
            errors++;
            $display("FAIL internal_zero: got %h expected F9C078", {s2a, s1a, s0a});
        end
        run_conv(8'd5, 3'b110);
        checks++;
        if ({s2a, s1a, s0a} !== 24'h7F7F92) begin
            errors++;
            $display("FAIL dp_on_blank: got %h expected 7F7F92", {s2a, s1a, s0a});
        end
        checks++;
        if ({s2b, s1b, s0b} !== 24'h404092) begin
            errors++;
            $display("FAIL dp_nolzb: got %h expected 404092", {s2b, s1b, s0b});
        end
    endtask

    task automatic test_ignore_start;
        int dones;
        logic [23:0] seen;
        dones = 0;
        seen  = 24'h0;
        bin   = 8'd42;
        dp    = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = 8'd77;
        dp    = 3'b111;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd9;
        dp    = 3'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (done_a) begin
                dones++;
                seen = {s2a, s1a, s0a};
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d expected 1", dones);
        end
        checks++;
        if (seen !== 24'hFF99A4) begin
            errors++;
            $display("FAIL ignore_segs: got %h expected FF99A4", seen);
        end
    endtask

    task automatic test_abort;
        bit no_done;
        bin   = 8'd200;
        dp    = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({s2a, s1a, s0a} !== 24'hFFFFFF || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: got segs=%h busy=%b done=%b expected FFFFFF 0 0",
                     {s2a, s1a, s0a}, busy_a, done_a);
        end
        no_done = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            if (done_a !== 1'b0) no_done = 1'b0;
        end
        checks++;
        if (!no_done || {s2a, s1a, s0a} !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL abort_no_done: got done_seen=%b segs=%h expected 0 FFFFFF",
                     !no_done, {s2a, s1a, s0a});
        end
        run_conv(8'd5, 3'd0);
        checks++;
        if (lat !== 9 || {s2a, s1a, s0a} !== 24'hFFFF92) begin
            errors++;
            $display("FAIL post_reset: got lat=%0d segs=%h expected 9 FFFF92",
                     lat, {s2a, s1a, s0a});
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] ea, eb;
        logic [2:0]  d;
        int          bad_a, bad_b, bad_lat;
        bad_a   = 0;
        bad_b   = 0;
        bad_lat = 0;
        for (int b = 0; b < 256; b++) begin
            d  = 3'(b);
            ea = ref_segs(b, d, 1'b1);
            eb = ref_segs(b, d, 1'b0);
            run_conv(8'(b), d);
            checks++;
            if (lat !== 9 || !done_b_ok) begin
                errors++;
                bad_lat++;
                $display("FAIL sweep_latency bin=%0d: got lat=%0d done_match=%b expected 9 1",
                         b, lat, done_b_ok);
            end
            checks++;
            if ({s2a, s1a, s0a} !== ea) begin
                errors++;
                bad_a++;
                $display("FAIL sweep_lzb bin=%0d: got %h expected %h", b, {s2a, s1a, s0a}, ea);
            end
            checks++;
            if ({s2b, s1b, s0b} !== eb) begin
                errors++;
                bad_b++;
                $display("FAIL sweep_nolzb bin=%0d: got %h expected %h", b, {s2b, s1b, s0b}, eb);
            end
            if (bad_a + bad_b + bad_lat > 20) break;
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_internal_zero_dp();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
